// File: rtl/shift_data_deser_pkg.sv
// Shared constants and elaboration helpers for the shift_data_deser block.
package shift_pkg;

    // Bit positions inside the sticky flag vector.
    localparam int FLG_OVF  = 0;
    localparam int FLG_SYNC = 1;
    localparam int FLG_PAR  = 2;
    localparam int NFLG     = 3;

    function automatic int frame_bits(input int mwidth, input int gsize, input int dwidth);
        return mwidth * gsize * dwidth;
    endfunction

    function automatic int beats_of(input int frame, input int lanes);
        return frame / lanes;
    endfunction

    // Ceiling log2 that never returns 0, so a 1-beat frame still gets a 1-bit counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shift_data_deser_if.sv
// Serial beat input and parallel frame output of the deserializer.
interface shift_data_deser_if #(
    parameter int LANES = 1,
    parameter int FRAME = 4096
) ();
    logic [LANES-1:0] sig_i;
    logic             sig_vld_i;
    logic             sof_i;
    logic             par_i;
    logic             rdy_i;
    logic [FRAME-1:0] sig_o;
    logic             vld_o;

    modport master (
        output sig_i, sig_vld_i, sof_i, par_i, rdy_i,
        input  sig_o, vld_o
    );

    modport slave (
        input  sig_i, sig_vld_i, sof_i, par_i, rdy_i,
        output sig_o, vld_o
    );
endinterface

// File: rtl/shift_data_deser_beat_cnt.sv
// Beat position tracker: sof restart, wrap after BEATS-1, first/last strobes.
module shift_beat_cnt #(
    parameter int BEATS = 4,
    parameter int BW    = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic beat_i,
    input  logic sof_i,
    output logic first_o,
    output logic last_o,
    output logic sync_o
);
    localparam logic [BW-1:0] LAST_IDX  = BW'(BEATS - 1);
    localparam logic [BW-1:0] AFTER_SOF = (BEATS == 1) ? '0 : BW'(1);

    logic [BW-1:0] cnt_p0;
    logic [BW-1:0] cnt_nxt;
    logic          at_last;

    assign at_last = (cnt_p0 == LAST_IDX);
    assign first_o = beat_i && (sof_i || (cnt_p0 == '0));
    // An sof beat is beat 0, so it only closes a frame when the frame is one beat long.
    assign last_o  = beat_i && (sof_i ? (BEATS == 1) : at_last);
    assign sync_o  = beat_i && sof_i && (cnt_p0 != '0);

    always_comb begin
        cnt_nxt = cnt_p0;
        if (beat_i) begin
            if (sof_i)        cnt_nxt = AFTER_SOF;
            else if (at_last) cnt_nxt = '0;
            else              cnt_nxt = cnt_p0 + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) cnt_p0 <= '0;
        else        cnt_p0 <= cnt_nxt;
    end

endmodule

// File: rtl/shift_data_deser.sv
// LANES-bit serial-in deserializer with a one-frame hold buffer and sticky error flags.
// Optional frame parity check enabled by defining SHIFT_DATA_DESER_PARITY_EN.
module shift_data_deser
    import shift_pkg::*;
#(
    parameter int MWIDTH = 4,
    parameter int GSIZE  = 8,
    parameter int DWIDTH = 128,
    parameter int LANES  = 1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            clr_n,
    shift_data_deser_if.slave bus,
    input  logic            err_clr_i,
    output logic            ovf_o,
    output logic            sync_err_o,
    output logic            par_err_o,
    output logic [CNTW-1:0] frm_cnt_o
);
    localparam int FRAME = frame_bits(MWIDTH, GSIZE, DWIDTH);
    localparam int BEATS = beats_of(FRAME, LANES);
    localparam int BW    = clog2_min1(BEATS);
    localparam int SW    = FRAME - LANES;

    generate
        if ((FRAME % LANES) != 0) begin : g_bad_lanes
            $error("shift_data_deser: LANES must divide MWIDTH*GSIZE*DWIDTH");
        end
    endgenerate

    logic             beat;
    logic             first_beat;
    logic             last_beat;
    logic             sync_hit;
    logic             load;
    logic             drop;
    logic             par_bad;
    logic [FRAME-1:0] frame_nxt;
    logic [FRAME-1:0] hold_p1;
    logic             vld_p1;
    logic [CNTW-1:0]  frm_cnt_p1;
    logic [NFLG-1:0]  flg_set;
    logic [NFLG-1:0]  flg_p1;

    assign beat = bus.sig_vld_i;

    shift_beat_cnt #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_beat_cnt (
        .clk     (clk),
        .clr_n   (clr_n),
        .beat_i  (beat),
        .sof_i   (bus.sof_i),
        .first_o (first_beat),
        .last_o  (last_beat),
        .sync_o  (sync_hit)
    );

    // Stage p0: shift register. Only the FRAME-LANES bits that survive into the
    // next frame are stored; stale bits of a discarded frame shift out naturally.
    generate
        if (BEATS == 1) begin : g_single
            assign frame_nxt = bus.sig_i;
        end else begin : g_shift
            logic [SW-1:0] shreg_p0;

            assign frame_nxt = {shreg_p0, bus.sig_i};

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n)    shreg_p0 <= '0;
                else if (beat) shreg_p0 <= frame_nxt[SW-1:0];
            end
        end
    endgenerate

`ifdef SHIFT_DATA_DESER_PARITY_EN
    logic par_acc_p0;
    logic frm_xor;

    assign frm_xor = (first_beat ? 1'b0 : par_acc_p0) ^ (^bus.sig_i);
    assign par_bad = last_beat && (frm_xor != bus.par_i);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)    par_acc_p0 <= 1'b0;
        else if (beat) par_acc_p0 <= frm_xor;
    end
`else
    assign par_bad = last_beat & bus.par_i & first_beat & 1'b0;
`endif

    // Stage p1: hold buffer accepts a frame when empty or draining on this edge.
    assign load = last_beat && (!vld_p1 || bus.rdy_i);
    assign drop = last_beat && vld_p1 && !bus.rdy_i;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hold_p1    <= '0;
            vld_p1     <= 1'b0;
            frm_cnt_p1 <= '0;
        end else begin
            if (load) begin
                hold_p1    <= frame_nxt;
                frm_cnt_p1 <= frm_cnt_p1 + CNTW'(1);
            end
            vld_p1 <= load || (vld_p1 && !bus.rdy_i);
        end
    end

    always_comb begin
        flg_set           = '0;
        flg_set[FLG_OVF]  = drop;
        flg_set[FLG_SYNC] = sync_hit;
        flg_set[FLG_PAR]  = par_bad;
    end

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) flg_p1 <= '0;
        else        flg_p1 <= flg_set | (flg_p1 & ~{NFLG{err_clr_i}});
    end

    assign bus.sig_o  = hold_p1;
    assign bus.vld_o  = vld_p1;
    assign frm_cnt_o  = frm_cnt_p1;
    assign ovf_o      = flg_p1[FLG_OVF];
    assign sync_err_o = flg_p1[FLG_SYNC];
    assign par_err_o  = flg_p1[FLG_PAR];

endmodule

// File: doc/shift_data_deser.md
Name: shift_data_deser

Overview:
- Parametrised successor to the single-bit serial-in shifter. Collects LANES bits per valid beat into a MWIDTH*GSIZE*DWIDTH frame.
- Supports frame alignment (sof_i) and double buffering, so shifting continues while the previous frame waits.
- Presents completed frames on a valid/ready parallel port feeding the gsm_unit group, with overflow/sync error flags and a frame counter.

Parameters:
- MWIDTH, 4, multicast width (output ports)
- GSIZE, 8, gsm_units per group
- DWIDTH, 128, data width per unit
- LANES, 1, serial bits per beat; must divide FRAME (elaboration error otherwise)
- CNTW, 16, frame counter width
- Derived: FRAME = MWIDTH*GSIZE*DWIDTH; BEATS = FRAME/LANES; BW = clog2(BEATS), minimum 1

Ports:
- clk  in  1  clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- sig_i  in  LANES  serial beat data
- sig_vld_i  in  1  beat valid
- sof_i  in  1  first beat of frame, qualified by sig_vld_i
- par_i  in  1  frame parity, sampled on last beat (used only with macro)
- rdy_i  in  1  downstream ready
- err_clr_i  in  1  synchronous clear of sticky flags
- sig_o  out  FRAME  assembled frame
- vld_o  out  1  frame valid
- ovf_o  out  1  sticky: frame dropped, hold buffer full
- sync_err_o  out  1  sticky: sof_i seen with beat count != 0
- par_err_o  out  1  sticky parity error (macro only; tied 0 otherwise)
- frm_cnt_o  out  CNTW  count of frames delivered to hold, wraps

Behaviour:
- Reset: clr_n low clears asynchronously shift reg, beat count, sig_o, vld_o, ovf_o, sync_err_o, par_err_o, frm_cnt_o; any partial frame is lost.
- Shift: on each beat (sig_vld_i=1), shreg <= {shreg[FRAME-LANES-1:0], sig_i}. First beat ends up in the MSBs. With sig_vld_i=0, shreg and count hold.
- Beat count: increments per beat; wraps to 0 after beat BEATS-1.
- sof_i with sig_vld_i:
  - That beat is beat 0; count becomes 1.
  - If count was nonzero, the partial frame is discarded and sync_err_o is set.
  - sof_i on a beat that would also be the last of the previous frame still restarts the frame (sync error).
- sof_i is not required: free-running alignment is legal.
- Frame complete: the last beat's edge loads hold/sig_o with {shreg[FRAME-LANES-1:0], sig_i} only if vld_o=0, or vld_o=1 and rdy_i=1 in that cycle.
  - vld_o=1 on the following cycle; latency is 1 clk from the last beat.
  - frm_cnt_o increments on each load.
- Hold full (vld_o=1, rdy_i=0) at frame complete: new frame dropped, ovf_o set, sig_o unchanged.
- Handshake: transfer when vld_o and rdy_i; vld_o clears next cycle unless a new frame loads on the same edge. sig_o retains its value after transfer. rdy_i with vld_o=0 has no effect.
- Sticky flags clear only by reset or err_clr_i. A set event in the same cycle as err_clr_i wins (flag stays 1).
- BEATS=1 is legal: every beat completes a frame.

Optional Feature:
- Macro SHIFT_DATA_DESER_PARITY_EN.
- Defined:
  - Running XOR of all received bits for the current frame; reset at frame start.
  - At frame complete, if XOR(frame) != par_i, par_err_o is set. The check applies even to dropped frames.
- Undefined: no parity logic; par_i ignored; par_err_o constant 0.

Decomposition:
- Package shift_pkg: FRAME/BEATS derivation function, clog2 helper, flag bit indices.
- One natural sub-module, shift_beat_cnt: beat counter with sof restart, wrap, and last-beat strobe.
- Datapath, hold buffer and flags stay in the top.

Test Plan (MWIDTH=1, GSIZE=1, DWIDTH=8, LANES=2 → FRAME=8, BEATS=4):
- Beats 10,11,00,01 (sof on first, one idle cycle between beats 2 and 3), rdy_i=1 -> sig_o=8'hB1, vld_o high exactly 1 cycle after beat 4, frm_cnt_o=1, no flags.
- Frame 8'hB1 then 8'h3C back-to-back, rdy_i=0 -> ovf_o=1, sig_o stays 8'hB1, frm_cnt_o=1. Then rdy_i=1 -> vld_o drops.
- Hold full with 8'hB1, rdy_i=1 on the same cycle as the last beat of 8'h3C -> sig_o=8'h3C, vld_o stays 1, ovf_o=0, frm_cnt_o=2.
- Two beats, then sof_i with beats 11,11,11,11 -> sync_err_o=1, sig_o=8'hFF. Then err_clr_i -> sync_err_o=0.
- clr_n low after 3 beats, then release and send 01,01,01,01 -> all outputs 0 during reset; next frame sig_o=8'h55.
- Macro defined, frame 8'hB1 (XOR=0) with par_i=1 -> par_err_o=1. Macro undefined, same stimulus -> par_err_o=0.
